// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: 2-entry fetch queue, immediate-format
// classification, load-use bubble insertion and flush handling.
module decode_issue_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_inst,
    input  logic [31:0]      if_pc,
    output logic             if_ready,
    input  logic             flush,
    output logic             id_valid,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [2:0]       id_fmt,
    input  logic             ex_ready,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [31:0] q_inst [2];
    logic [31:0] q_pc   [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [1:0]  hz_cnt;
    logic [4:0]  hz_rd;

    logic        empty;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fmt;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        stall;
    logic        push;
    logic        pop;
    logic        bump;

    assign empty    = (count == 2'd0);
    assign if_ready = (count != 2'd2) & ~rst;
    assign id_inst  = (empty | rst) ? 32'd0 : q_inst[rd_ptr];
    assign id_pc    = (empty | rst) ? 32'd0 : q_pc[rd_ptr];

    assign opcode = id_inst[6:0];
    assign rd     = id_inst[11:7];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];

    always_comb begin
        fmt = 3'd0;
        unique case (1'b1)
            (opcode == 7'h03) || (opcode == 7'h13) ||
            (opcode == 7'h67) || (opcode == 7'h73): fmt = 3'd1;
            (opcode == 7'h23):                      fmt = 3'd2;
            (opcode == 7'h63):                      fmt = 3'd3;
            (opcode == 7'h17) || (opcode == 7'h37): fmt = 3'd4;
            (opcode == 7'h6F):                      fmt = 3'd5;
            default:                                fmt = 3'd0;
        endcase
    end

    assign id_fmt   = fmt;
    assign uses_rs1 = (fmt != 3'd4) && (fmt != 3'd5);
    assign uses_rs2 = (fmt == 3'd0) || (fmt == 3'd2) || (fmt == 3'd3);

    assign stall = (hz_cnt != 2'd0) &
                   ((uses_rs1 & (rs1 == hz_rd)) | (uses_rs2 & (rs2 == hz_rd)));

    assign id_valid = ~empty & ~stall & ~flush & ~rst;
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & ex_ready;
    assign bump     = ~empty & stall & ex_ready & ~flush;

    // Payload storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= if_inst;
            q_pc[wr_ptr]   <= if_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            hz_cnt     <= 2'd0;
            hz_rd      <= 5'd0;
            bubble_cnt <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            hz_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;

            if (pop && (opcode == 7'h03) && (rd != 5'd0)) begin
                hz_cnt <= 2'(LOAD_LAT);
                hz_rd  <= rd;
            end else if ((hz_cnt != 2'd0) && ex_ready) begin
                hz_cnt <= hz_cnt - 2'd1;
            end

            if (bump && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Randomized and directed bench for decode_issue_ctrl against a
// queue-based behavioural model.
module tb_decode_issue_ctrl;

    localparam int LL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = 32'd0;
    logic [31:0] if_pc = 32'd0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;

    logic        if_ready, id_valid;
    logic [31:0] id_inst, id_pc;
    logic [2:0]  id_fmt;
    logic [15:0] bubble_cnt;

    logic        if_ready2, id_valid2;
    logic [31:0] id_inst2, id_pc2;
    logic [2:0]  id_fmt2;
    logic [3:0]  bubble_cnt2;

    decode_issue_ctrl #(.LOAD_LAT(LL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst),
        .if_pc(if_pc), .if_ready(if_ready), .flush(flush),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .id_fmt(id_fmt), .ex_ready(ex_ready), .bubble_cnt(bubble_cnt)
    );

    decode_issue_ctrl #(.LOAD_LAT(LL), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst),
        .if_pc(if_pc), .if_ready(if_ready2), .flush(flush),
        .id_valid(id_valid2), .id_inst(id_inst2), .id_pc(id_pc2),
        .id_fmt(id_fmt2), .ex_ready(ex_ready), .bubble_cnt(bubble_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t mq[$];
    int   hz = 0;
    int   hzrd = 0;
    int   bub = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int fmt_of(input logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return 1;
            7'h23: return 2;
            7'h63: return 3;
            7'h17, 7'h37: return 4;
            7'h6F: return 5;
            default: return 0;
        endcase
    endfunction

    // One cycle: drive, compare against model, advance model.
    task automatic step(input logic r, input logic v, input logic [31:0] inst,
                        input logic [31:0] pc, input logic f, input logic e);
        ent_t h;
        int   fm;
        bit   st, u1, u2, ev, er, iss;
        int   sat;
        @(negedge clk);
        rst = r; if_valid = v; if_inst = inst; if_pc = pc;
        flush = f; ex_ready = e;
        #1;
        er = !r && (mq.size() < 2);
        if (mq.size() > 0 && !r) h = mq[0];
        else begin h.inst = 0; h.pc = 0; end
        fm = fmt_of(h.inst);
        u1 = !(fm == 4 || fm == 5);
        u2 = (fm == 0 || fm == 2 || fm == 3);
        st = (hz != 0) && ((u1 && int'(h.inst[19:15]) == hzrd) ||
                           (u2 && int'(h.inst[24:20]) == hzrd));
        ev = (mq.size() != 0) && !st && !f && !r;
        sat = (bub > 15) ? 15 : bub;
        chk("if_ready", 32'(if_ready), 32'(er));
        chk("id_valid", 32'(id_valid), 32'(ev));
        chk("id_inst", id_inst, h.inst);
        chk("id_pc", id_pc, h.pc);
        chk("id_fmt", 32'(id_fmt), 32'(fm));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(bub));
        chk("bubble_sat4", 32'(bubble_cnt2), 32'(sat));
        chk("id_valid_w4", 32'(id_valid2), 32'(ev));
        if (r) begin
            mq.delete(); hz = 0; hzrd = 0; bub = 0;
        end else if (f) begin
            mq.delete(); hz = 0;
        end else begin
            if (mq.size() != 0 && st && e && bub < 65535) bub++;
            iss = ev && e;
            if (iss && h.inst[6:0] == 7'h03 && h.inst[11:7] != 0) begin
                hz = LL; hzrd = int'(h.inst[11:7]);
            end else if (hz != 0 && e) begin
                hz--;
            end
            if (iss) void'(mq.pop_front());
            if (v && er) begin
                ent_t n;
                n.inst = inst; n.pc = pc;
                mq.push_back(n);
            end
        end
    endtask

    task automatic idle(input logic e);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, e);
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc,
                        input logic e);
        step(1'b0, 1'b1, inst, pc, 1'b0, e);
    endtask

    // Load followed by a second instruction, both from an empty queue.
    task automatic pair(input logic [31:0] a, input logic [31:0] b,
                        input logic v3, input int exp_bub);
        push(a, 32'h100, 1'b1);
        push(b, 32'h104, 1'b1);
        idle(1'b1);
        chk("pair_v3", 32'(id_valid), 32'(v3));
        chk("pair_head", id_inst, b);
        idle(1'b1);
        chk("pair_bub", 32'(bubble_cnt), 32'(exp_bub));
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [6:0] ops [11];
        logic [6:0] op;
        ops = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17,
                7'h63, 7'h67, 7'h6F, 7'h73, 7'h03};
        op = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 15) == 0) op = 7'($urandom);
        return {7'($urandom), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom_range(0, 3)), op};
    endfunction

    localparam logic [31:0] LW5  = 32'h0000A283;
    localparam logic [31:0] ADDD = 32'h00728333;
    localparam logic [31:0] ADDI = 32'h00838333;
    localparam logic [31:0] LW0  = 32'h0000A003;
    localparam logic [31:0] ADD0 = 32'h00700333;
    localparam logic [31:0] SW5  = 32'h00512023;

    initial begin
        logic [6:0]  sw_ops [7];
        int          sw_fmt [7];
        logic [31:0] pc;

        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h13, 0, 1'b0, 1'b1);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);

        push(32'h00100093, 32'h0, 1'b1);
        idle(1'b1);
        chk("addi_valid", 32'(id_valid), 32'd1);
        chk("addi_inst", id_inst, 32'h00100093);
        chk("addi_fmt", 32'(id_fmt), 32'd1);
        chk("addi_pc", id_pc, 32'h0);
        idle(1'b1);
        chk("addi_gone", 32'(id_valid), 32'd0);
        chk("addi_gone_inst", id_inst, 32'd0);

        push(32'h00000013, 32'h0, 1'b0);
        push(32'h00000013, 32'h4, 1'b0);
        push(32'h00000013, 32'h8, 1'b0);
        chk("full_no_ready", 32'(if_ready), 32'd0);
        push(32'h00000013, 32'h8, 1'b1);
        chk("full_pop_no_ready", 32'(if_ready), 32'd0);
        chk("order0", id_pc, 32'h0);
        push(32'h00000013, 32'h8, 1'b1);
        chk("order1", id_pc, 32'h4);
        idle(1'b1);
        chk("order2", id_pc, 32'h8);
        chk("order2_v", 32'(id_valid), 32'd1);
        idle(1'b1);

        pair(LW5, ADDD, 1'b0, 1);
        pair(LW5, ADDI, 1'b1, 1);
        pair(LW0, ADD0, 1'b1, 1);
        pair(LW5, SW5, 1'b0, 2);

        push(LW5, 32'h200, 1'b1);
        push(ADDD, 32'h204, 1'b1);
        push(ADDI, 32'h208, 1'b0);
        step(1'b0, 1'b1, 32'h00000013, 32'h20C, 1'b1, 1'b1);
        chk("flush_valid", 32'(id_valid), 32'd0);
        idle(1'b1);
        chk("post_flush_ready", 32'(if_ready), 32'd1);
        chk("post_flush_empty", 32'(id_valid), 32'd0);
        push(ADDD, 32'h300, 1'b1);
        idle(1'b1);
        chk("post_flush_nostall", 32'(id_valid), 32'd1);
        chk("post_flush_head", id_pc, 32'h300);

        sw_ops = '{7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73};
        sw_fmt = '{2, 3, 4, 4, 5, 0, 1};
        for (int i = 0; i < 7; i++) begin
            push({25'd0, sw_ops[i]}, 32'h400 + 32'(i * 4), 1'b0);
            idle(1'b0);
            chk("fmt_sweep", 32'(id_fmt), 32'(sw_fmt[i]));
            idle(1'b1);
        end

        pc = 32'h1000;
        for (int c = 0; c < 4000; c++) begin
            logic r, v, f, e;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 14) == 0);
            v = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 3) != 0);
            step(r, v, rnd_inst(), pc, f, e);
            pc = pc + 32'd4;
        end

        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            pair(LW5, ADDD, 1'b0, i + 1);
        chk("sat_w16", 32'(bubble_cnt), 32'd20);
        chk("sat_w4", 32'(bubble_cnt2), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
Decode-stage issue controller for the RISC-V core. It sits between fetch and execute. It buffers fetched instructions in a 2-entry queue with valid/ready handshakes on both sides. It classifies each instruction's immediate format for the immediate generator and ALU-operand muxes. It inserts bubbles on load-use hazards and discards queued work on a branch/jump flush.

Parameters:
LOAD_LAT, 1, number of ex_ready-qualified cycles after a load issues during which a dependent instruction is withheld (1..3)
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
if_valid  in  1  fetch presents an instruction
if_inst  in  32  fetched instruction
if_pc  in  32  PC of if_inst
if_ready  out  1  queue can accept (push = if_valid & if_ready & ~flush)
flush  in  1  branch/jump redirect; kill all queued and pending state
id_valid  out  1  head instruction is issuable
id_inst  out  32  head instruction (0 when queue empty)
id_pc  out  32  head PC (0 when queue empty)
id_fmt  out  3  head immediate format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J (0 when empty)
ex_ready  in  1  execute accepts (issue = id_valid & ex_ready)
bubble_cnt  out  CNT_W  saturating count of hazard-bubble cycles

Behaviour:
- Reset (rst high at posedge): queue count=0, rd/wr pointers=0, hazard counter=0, hazard rd=0, bubble_cnt=0. While rst is high: if_ready=0, id_valid=0, id_inst/id_pc/id_fmt=0.
- Queue: 2 entries storing {inst, pc}, circular pointers with wrap at 2.
  - if_ready = (count<2) & ~rst. No push-through-when-full: if_ready stays 0 when count=2, even if a pop occurs that cycle.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Latency: an instruction pushed at edge N is visible on id_* in the cycle after edge N. There is no combinational bypass from if_* to id_*.
- Format decode of head opcode inst[6:0]:
  - 0x03, 0x13, 0x67, 0x73 -> 1
  - 0x23 -> 2
  - 0x63 -> 3
  - 0x17, 0x37 -> 4
  - 0x6F -> 5
  - all others -> 0
- Register fields: rd=inst[11:7], rs1=inst[19:15], rs2=inst[24:20].
  - Head uses rs1 if fmt is not in {4,5}.
  - Head uses rs2 if fmt is in {0,2,3}.
- Hazard tracking:
  - On issue of an instruction with opcode 0x03 and rd!=0: hz_cnt<=LOAD_LAT, hz_rd<=rd.
  - Otherwise, if hz_cnt!=0 and ex_ready=1: hz_cnt decrements by 1.
  - If ex_ready=0, hz_cnt holds.
  - stall = (hz_cnt!=0) & ((uses_rs1 & rs1==hz_rd) | (uses_rs2 & rs2==hz_rd)).
  - A load with rd=x0 never arms the hazard.
- Issue:
  - id_valid = (count!=0) & ~stall & ~flush & ~rst.
  - Pop on issue.
  - A stall does not block fetch pushes into the free entry.
- bubble_cnt increments when count!=0 & stall & ex_ready & ~flush. It saturates at all-ones with no wrap.
- Flush:
  - Has priority over push and pop in the same cycle. id_valid is forced 0 in the flush cycle, and a push in that cycle is dropped.
  - Next cycle: count=0, pointers=0, hz_cnt=0.
  - bubble_cnt is not cleared.
- Reset mid-operation follows the reset clause above; all queued instructions are lost.

Test Plan:
- Reset, push ADDI x1,x0,1 (0x00100093, pc 0x0), ex_ready=1 -> next cycle id_valid=1, id_inst=0x00100093, id_fmt=1, id_pc=0; popped that cycle, then id_valid=0, id_inst=0.
- ex_ready=0, fetch offers 3 instructions back-to-back -> first 2 accepted, if_ready=0 from the cycle after the 2nd push, 3rd held by fetch. Then ex_ready=1 -> issue order pc 0x0, 0x4, 0x8 with no loss or duplication.
- LOAD_LAT=1: LW x5,0(x1) (0x0000A283) followed by ADD x6,x5,x7 (0x00728333) -> ADD id_valid=0 for exactly 1 cycle, bubble_cnt=1. Repeat with ADD x6,x7,x8 (0x00838333) -> no bubble.
- LW x0,0(x1) (0x0000A003) followed by ADD x6,x0,x7 -> no stall. With LOAD_LAT=1, the load followed by dependent SW x5,0(x2) (0x00512023, rs2=x5) -> 1-cycle stall.
- Two entries queued and hazard armed, flush=1 with if_valid=1 -> id_valid=0 that cycle. Next cycle count=0, if_ready=1, stall clear, dropped instruction never issues.
- Format sweep, opcodes 0x23/0x63/0x37/0x17/0x6F/0x33/0x73 -> id_fmt 2/3/4/4/5/0/1. Force 2^16 stall cycles with CNT_W=16 -> bubble_cnt holds 0xFFFF.
